boot_sequencer: RTL

Reset-and-load sequencer for the mini-MIPS core. It takes a program image as a valid/ready word stream and holds the core in reset while it writes that image into instruction and data memory, using the core's load ports (`inst_data_in`/`inst_write_addr`, `mem_data_in`/`mem_write_addr`). It then releases reset and counts execution cycles against an optional budget. It sits between the testbench or host stream and the core's `rst` input.

---
 rtl/boot_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer: holds the mini-MIPS core in reset while a program image,
// streamed as valid/ready words, is written into instruction and data
// memory through the core's load ports. It then releases reset and counts
// execution cycles against an optional budget.
//
// Image format: a header word {N_I[15:0], N_D[15:0]} followed by N_I
// instruction words and then N_D data words. Each region is written from
// word address 0 upward.
module boot_sequencer #(
    parameter int          RESET_HOLD  = 2,
    parameter logic [31:0] CYCLE_LIMIT = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        cpu_rst,
    output logic [31:0] inst_data_out,
    output logic [31:0] inst_write_addr,
    output logic [31:0] mem_data_out,
    output logic [31:0] mem_write_addr,
    output logic        inst_we,
    output logic        mem_we,
    output logic        busy,
    output logic        running,
    output logic        done,
    output logic [31:0] run_count
);

    // A hold of zero cycles would let the core out of reset while the last
    // write strobe is still in flight, so it is treated as one.
    localparam int          HOLD_N    = (RESET_HOLD < 1) ? 1 : RESET_HOLD;
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_LOAD_I = 3'd2,
        S_LOAD_D = 3'd3,
        S_HOLD   = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ni_q, ni_d;          // instruction word count from header
    logic [15:0] nd_q, nd_d;          // data word count from header
    logic [15:0] k_q, k_d;            // word index within current region
    logic [31:0] hold_q, hold_d;      // cycles spent in HOLD so far
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        inst_we_q, inst_we_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] run_q, run_d;
    logic        done_q, done_d;

    logic        ready_w;
    logic        accept;

    // Handshake and status flags are pure decodes of the state register.
    assign ready_w = (state_q == S_HEADER) || (state_q == S_LOAD_I) ||
                     (state_q == S_LOAD_D);
    assign accept  = s_valid && ready_w;

    assign s_ready         = ready_w;
    assign cpu_rst         = (state_q != S_RUN);
    assign busy            = ready_w || (state_q == S_HOLD);
    assign running         = (state_q == S_RUN);
    assign done            = done_q;
    assign run_count       = run_q;
    assign inst_data_out   = inst_data_q;
    assign inst_write_addr = inst_addr_q;
    assign mem_data_out    = mem_data_q;
    assign mem_write_addr  = mem_addr_q;
    assign inst_we         = inst_we_q;
    assign mem_we          = mem_we_q;

    // Next-state and datapath decode; write strobes default low so each
    // accepted word produces exactly one strobe cycle.
    always_comb begin
        state_d     = state_q;
        ni_d        = ni_q;
        nd_d        = nd_q;
        k_d         = k_q;
        hold_d      = '0;
        inst_data_d = inst_data_q;
        inst_addr_d = inst_addr_q;
        mem_data_d  = mem_data_q;
        mem_addr_d  = mem_addr_q;
        inst_we_d   = 1'b0;
        mem_we_d    = 1'b0;
        run_d       = run_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HEADER;
                    run_d   = '0;
                    done_d  = 1'b0;
                end
            end

            S_HEADER: begin
                if (accept) begin
                    ni_d = s_data[31:16];
                    nd_d = s_data[15:0];
                    k_d  = '0;
                    if (s_data[31:16] != 16'd0)
                        state_d = S_LOAD_I;
                    else if (s_data[15:0] != 16'd0)
                        state_d = S_LOAD_D;
                    else
                        state_d = S_HOLD;
                end
            end

            S_LOAD_I: begin
                if (accept) begin
                    inst_data_d = s_data;
                    inst_addr_d = {16'd0, k_q};
                    inst_we_d   = 1'b1;
                    if (k_q == ni_q - 16'd1) begin
                        k_d     = '0;
                        state_d = (nd_q != 16'd0) ? S_LOAD_D : S_HOLD;
                    end else begin
                        k_d = k_q + 16'd1;
                    end
                end
            end

            S_LOAD_D: begin
                if (accept) begin
                    mem_data_d = s_data;
                    mem_addr_d = {16'd0, k_q};
                    mem_we_d   = 1'b1;
                    if (k_q == nd_q - 16'd1) begin
                        k_d     = '0;
                        state_d = S_HOLD;
                    end else begin
                        k_d = k_q + 16'd1;
                    end
                end
            end

            S_HOLD: begin
                if (hold_q == HOLD_LAST)
                    state_d = S_RUN;
                else
                    hold_d = hold_q + 32'd1;
            end

            S_RUN: begin
                if (start) begin
                    // Reload: the core goes back into reset next cycle.
                    state_d = S_HEADER;
                    run_d   = '0;
                    done_d  = 1'b0;
                end else if (CYCLE_LIMIT == 32'd0) begin
                    run_d = run_q + 32'd1;
                end else if (run_q != CYCLE_LIMIT) begin
                    // Budget counting saturates at the limit; the core
                    // itself keeps running.
                    run_d  = run_q + 32'd1;
                    done_d = ((run_q + 32'd1) == CYCLE_LIMIT);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers: counters, load-port outputs and run accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            ni_q        <= '0;
            nd_q        <= '0;
            k_q         <= '0;
            hold_q      <= '0;
            inst_data_q <= '0;
            inst_addr_q <= '0;
            mem_data_q  <= '0;
            mem_addr_q  <= '0;
            inst_we_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            run_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            ni_q        <= ni_d;
            nd_q        <= nd_d;
            k_q         <= k_d;
            hold_q      <= hold_d;
            inst_data_q <= inst_data_d;
            inst_addr_q <= inst_addr_d;
            mem_data_q  <= mem_data_d;
            mem_addr_q  <= mem_addr_d;
            inst_we_q   <= inst_we_d;
            mem_we_q    <= mem_we_d;
            run_q       <= run_d;
            done_q      <= done_d;
        end
    end

endmodule
